// File: rtl/layer_sched32.sv
// rtl/layer_sched32.sv - sequences one shared neuron32 datapath across a fully-connected layer
// Per neuron: fetch weights/bias, pulse nrn_go, wait NEURON_LAT, write result under backpressure.
module layer_sched32 #(
  parameter int NUM_NEURONS = 32,
  parameter int NEURON_LAT  = 4,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   n_active,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [1023:0]     mem_rd_weights,
  input  logic [31:0]       mem_rd_bias,
  output logic [1023:0]     nrn_weights,
  output logic [31:0]       nrn_bias,
  output logic              nrn_go,
  input  logic [31:0]       nrn_activ,
  input  logic [31:0]       nrn_sigma,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_activ,
  output logic [31:0]       out_sigma,
  input  logic              out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int               NW       = ADDR_W + 1;
  localparam int               CNT_W    = (NEURON_LAT > 1) ? $clog2(NEURON_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NEURON_LAT - 1);
  localparam logic [NW-1:0]    N_MAX    = NW'(NUM_NEURONS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [NW-1:0]       n_eff_q, n_eff_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1023:0]       weights_q, weights_d;
  logic [31:0]         bias_q, bias_d;
  logic [31:0]         activ_q, activ_d;
  logic [31:0]         sigma_q, sigma_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [NW-1:0]       idx_ext;
  logic                last_nrn;

  // idx is compared in the wider n_eff domain so n_eff=NUM_NEURONS never overflows
  assign idx_ext  = {1'b0, idx_q};
  assign last_nrn = ((idx_ext + NW'(1)) == n_eff_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      n_eff_q   <= '0;
      cnt_q     <= '0;
      weights_q <= '0;
      bias_q    <= '0;
      activ_q   <= '0;
      sigma_q   <= '0;
      waddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_eff_q   <= n_eff_d;
      cnt_q     <= cnt_d;
      weights_q <= weights_d;
      bias_q    <= bias_d;
      activ_q   <= activ_d;
      sigma_q   <= sigma_d;
      waddr_q   <= waddr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_eff_d   = n_eff_q;
    cnt_d     = cnt_q;
    weights_d = weights_q;
    bias_d    = bias_q;
    activ_d   = activ_q;
    sigma_d   = sigma_q;
    waddr_d   = waddr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_eff_d = (n_active > N_MAX) ? N_MAX : n_active;
          idx_d   = '0;
          state_d = (n_active == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        weights_d = mem_rd_weights;
        bias_d    = mem_rd_bias;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          activ_d = nrn_activ;
          sigma_d = nrn_sigma;
          waddr_d = idx_q;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (out_ready) begin
          if (last_nrn) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // abort only redirects the FSM; datapath registers keep whatever this cycle produced
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign mem_rd_en   = (state_q == S_FETCH);
  assign mem_rd_addr = idx_q;
  assign nrn_weights = weights_q;
  assign nrn_bias    = bias_q;
  assign nrn_go      = (state_q == S_WAIT) && (cnt_q == '0);
  assign out_we      = (state_q == S_WRITE);
  assign out_addr    = waddr_q;
  assign out_activ   = activ_q;
  assign out_sigma   = sigma_q;

endmodule

// File: tb/tb_layer_sched32.sv
// tb/tb_layer_sched32.sv - self-checking bench for layer_sched32 against a cycle-timeline model
module tb_layer_sched32;

  localparam int NN   = 32;
  localparam int LAT  = 4;
  localparam int AW   = 5;
  localparam int MAXC = 1024;

  logic          clk;
  logic          rst_n, start, abort, out_ready;
  logic [AW:0]   n_active;
  logic          busy, done, mem_rd_en, nrn_go, out_we;
  logic [AW-1:0] mem_rd_addr, out_addr;
  logic [1023:0] mem_rd_weights, nrn_weights;
  logic [31:0]   mem_rd_bias, nrn_bias, nrn_activ, nrn_sigma, out_activ, out_sigma;

  layer_sched32 #(.NUM_NEURONS(NN), .NEURON_LAT(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_active(n_active),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_weights(mem_rd_weights), .mem_rd_bias(mem_rd_bias),
    .nrn_weights(nrn_weights), .nrn_bias(nrn_bias), .nrn_go(nrn_go),
    .nrn_activ(nrn_activ), .nrn_sigma(nrn_sigma), .out_we(out_we), .out_addr(out_addr),
    .out_activ(out_activ), .out_sigma(out_sigma), .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] w_tab [NN];
  logic [31:0] b_tab [NN];
  bit          r_tab [MAXC];
  bit          e_busy [MAXC];
  bit          e_done [MAXC];
  bit          e_rd   [MAXC];
  bit          e_go   [MAXC];
  bit          e_we   [MAXC];
  int          e_idx  [MAXC];

  int obs_done, obs_writes, obs_reads, obs_go_first, obs_busy, obs_we;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1023:0] mk_w(input logic [31:0] base);
    logic [1023:0] v;
    for (int j = 0; j < 32; j++) v[j*32 +: 32] = base ^ 32'(j);
    return v;
  endfunction

  function automatic logic [31:0] exp_act(input int i);
    return b_tab[i] ^ w_tab[i] ^ 32'hABCD_1001;
  endfunction

  function automatic logic [31:0] exp_sig(input int i);
    return b_tab[i] + (w_tab[i] ^ 32'd1);
  endfunction

  // weight memory: data valid only in the cycle after a read strobe, noise otherwise
  initial begin
    bit          pend;
    logic [AW-1:0] a;
    mem_rd_weights = '0;
    mem_rd_bias    = '0;
    forever begin
      @(negedge clk);
      pend = mem_rd_en;
      a    = mem_rd_addr;
      @(posedge clk);
      #1;
      if (pend) begin
        mem_rd_weights = mk_w(w_tab[a]);
        mem_rd_bias    = b_tab[a];
      end else begin
        mem_rd_weights = {32{$urandom}};
        mem_rd_bias    = $urandom;
      end
    end
  end

  // idealised datapath: result valid only in the last cycle of the evaluation window
  initial begin
    logic [31:0] oa, os;
    nrn_activ = '0;
    nrn_sigma = '0;
    forever begin
      @(negedge clk);
      if (nrn_go === 1'b1) begin
        oa = nrn_bias ^ nrn_weights[31:0] ^ 32'hABCD_1001;
        os = nrn_bias + nrn_weights[63:32];
        repeat (LAT - 1) @(posedge clk);
        #1;
        nrn_activ = oa;
        nrn_sigma = os;
        @(posedge clk);
        #1;
        nrn_activ = $urandom;
        nrn_sigma = $urandom;
      end
    end
  end

  task automatic rand_tables();
    for (int i = 0; i < NN; i++) begin
      w_tab[i] = $urandom;
      b_tab[i] = $urandom;
    end
  endtask

  // rdy_mode: 0 always ready, 1 random ready, 2 use preloaded r_tab
  task automatic run_pass(input int n, input int rdy_mode, input int abort_cyc, input bit noise);
    int ne, t, k, fin, stop;
    logic [31:0] ea, es;
    if (rdy_mode != 2)
      for (int c = 0; c < MAXC; c++) r_tab[c] = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    r_tab[MAXC-1] = 1'b1;
    for (int c = 0; c < MAXC; c++) begin
      e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_go[c] = 0; e_we[c] = 0; e_idx[c] = 0;
    end
    ne = (n > NN) ? NN : n;
    if (ne == 0) begin
      fin = 1;
    end else begin
      t = 1;
      for (int i = 0; i < ne; i++) begin
        e_rd[t] = 1; e_idx[t] = i;
        e_go[t+2] = 1; e_idx[t+2] = i;
        k = t + LAT + 2;
        while (!r_tab[k] && k < MAXC - 1) begin
          e_we[k] = 1; e_idx[k] = i; k++;
        end
        e_we[k] = 1; e_idx[k] = i;
        t = k + 1;
      end
      fin = t;
    end
    e_done[fin] = 1;
    for (int c = 1; c <= fin; c++) e_busy[c] = 1;
    stop = fin;
    if (abort_cyc > 0 && abort_cyc < fin) begin
      stop = abort_cyc;
      for (int c = abort_cyc + 1; c < MAXC; c++) begin
        e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_go[c] = 0; e_we[c] = 0;
      end
    end

    obs_done = 0; obs_writes = 0; obs_reads = 0; obs_go_first = 0; obs_busy = 0; obs_we = 0;
    @(negedge clk);
    start = 1'b1; n_active = n[AW:0]; abort = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= stop + 3; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== e_busy[c]) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", c, busy, e_busy[c]); end
      checks++;
      if (done !== e_done[c]) begin errors++; $display("FAIL done cyc=%0d got=%b exp=%b", c, done, e_done[c]); end
      checks++;
      if (mem_rd_en !== e_rd[c]) begin errors++; $display("FAIL mem_rd_en cyc=%0d got=%b exp=%b", c, mem_rd_en, e_rd[c]); end
      checks++;
      if (nrn_go !== e_go[c]) begin errors++; $display("FAIL nrn_go cyc=%0d got=%b exp=%b", c, nrn_go, e_go[c]); end
      checks++;
      if (out_we !== e_we[c]) begin errors++; $display("FAIL out_we cyc=%0d got=%b exp=%b", c, out_we, e_we[c]); end
      if (e_rd[c]) begin
        checks++;
        if (mem_rd_addr !== AW'(e_idx[c])) begin
          errors++; $display("FAIL mem_rd_addr cyc=%0d got=%0d exp=%0d", c, mem_rd_addr, e_idx[c]);
        end
      end
      if (e_go[c]) begin
        checks++;
        if (nrn_weights !== mk_w(w_tab[e_idx[c]]) || nrn_bias !== b_tab[e_idx[c]]) begin
          errors++; $display("FAIL nrn_operands cyc=%0d got_bias=%h exp_bias=%h", c, nrn_bias, b_tab[e_idx[c]]);
        end
      end
      if (e_we[c]) begin
        ea = exp_act(e_idx[c]);
        es = exp_sig(e_idx[c]);
        checks++;
        if (out_addr !== AW'(e_idx[c])) begin
          errors++; $display("FAIL out_addr cyc=%0d got=%0d exp=%0d", c, out_addr, e_idx[c]);
        end
        checks++;
        if (out_activ !== ea || out_sigma !== es) begin
          errors++; $display("FAIL out_data cyc=%0d got=%h/%h exp=%h/%h", c, out_activ, out_sigma, ea, es);
        end
      end
      if (done === 1'b1 && obs_done == 0) obs_done = c;
      if (nrn_go === 1'b1 && obs_go_first == 0) obs_go_first = c;
      if (busy === 1'b1) obs_busy++;
      if (out_we === 1'b1) obs_we++;
      if (mem_rd_en === 1'b1) obs_reads++;
      if (out_we === 1'b1 && r_tab[c]) obs_writes++;
      out_ready = r_tab[c];
      abort = (c == abort_cyc);
      if (noise && c <= stop) begin
        start = 1'($urandom_range(0, 1));
        n_active = (AW+1)'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, done, mem_rd_en, nrn_go, out_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, mem_rd_en, nrn_go, out_we});
    end
    checks++;
    if (mem_rd_addr !== '0 || out_addr !== '0 || nrn_weights !== '0 || nrn_bias !== '0 ||
        out_activ !== '0 || out_sigma !== '0) begin
      errors++; $display("FAIL reset_data got_activ=%h got_bias=%h exp=0", out_activ, nrn_bias);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, mem_rd_en, nrn_go, out_we} !== 5'b0) begin
        errors++; $display("FAIL idle_quiet cyc=%0d got=%b exp=00000", c, {busy, done, mem_rd_en, nrn_go, out_we});
      end
    end
  endtask

  task automatic test_single();
    rand_tables();
    w_tab[0] = 32'h0;
    b_tab[0] = 32'h0000_1000;
    run_pass(1, 0, 0, 0);
    checks++;
    if (obs_go_first != 3) begin errors++; $display("FAIL single_go got=%0d exp=3", obs_go_first); end
    checks++;
    if (obs_done != 8) begin errors++; $display("FAIL single_done got=%0d exp=8", obs_done); end
    checks++;
    if (obs_busy != 8) begin errors++; $display("FAIL single_busy got=%0d exp=8", obs_busy); end
    checks++;
    if (out_activ !== 32'hABCD_0001) begin errors++; $display("FAIL single_activ got=%h exp=abcd0001", out_activ); end
  endtask

  task automatic test_full();
    rand_tables();
    run_pass(32, 0, 0, 0);
    checks++;
    if (obs_done != 225) begin errors++; $display("FAIL full_done got=%0d exp=225", obs_done); end
    checks++;
    if (obs_writes != 32) begin errors++; $display("FAIL full_writes got=%0d exp=32", obs_writes); end
  endtask

  task automatic test_backpressure();
    rand_tables();
    for (int c = 0; c < MAXC; c++) r_tab[c] = 1'b1;
    r_tab[7] = 1'b0; r_tab[8] = 1'b0; r_tab[9] = 1'b0;
    run_pass(2, 2, 0, 0);
    checks++;
    if (obs_done != 18) begin errors++; $display("FAIL bp_done got=%0d exp=18", obs_done); end
    checks++;
    if (obs_we != 5) begin errors++; $display("FAIL bp_we_cycles got=%0d exp=5", obs_we); end
  endtask

  task automatic test_edge_counts();
    rand_tables();
    run_pass(0, 0, 0, 0);
    checks++;
    if (obs_done != 1) begin errors++; $display("FAIL zero_done got=%0d exp=1", obs_done); end
    checks++;
    if (obs_reads != 0 || obs_writes != 0) begin
      errors++; $display("FAIL zero_traffic got=%0d/%0d exp=0/0", obs_reads, obs_writes);
    end
    run_pass(40, 1, 0, 0);
    checks++;
    if (obs_writes != 32) begin errors++; $display("FAIL over_writes got=%0d exp=32", obs_writes); end
  endtask

  task automatic test_abort();
    rand_tables();
    run_pass(8, 0, 39, 0);
    checks++;
    if (obs_done != 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", obs_done); end
    checks++;
    if (obs_writes != 5) begin errors++; $display("FAIL abort_writes got=%0d exp=5", obs_writes); end
    run_pass(3, 1, 0, 0);
    checks++;
    if (obs_writes != 3) begin errors++; $display("FAIL restart_writes got=%0d exp=3", obs_writes); end
  endtask

  task automatic test_reset_mid();
    rand_tables();
    @(negedge clk);
    start = 1'b1; n_active = 6'd4; out_ready = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (out_we !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got=%b exp=1", out_we); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_we !== 1'b0 || busy !== 1'b0 || out_activ !== '0) begin
      errors++; $display("FAIL rst_mid_async got=%b/%b/%h exp=0/0/0", out_we, busy, out_activ);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_pass(2, 1, 0, 0);
    checks++;
    if (obs_writes != 2) begin errors++; $display("FAIL rst_mid_recover got=%0d exp=2", obs_writes); end
  endtask

  task automatic test_random();
    int n;
    for (int p = 0; p < 6; p++) begin
      rand_tables();
      n = $urandom_range(0, 63);
      run_pass(n, $urandom_range(0, 1), 0, 1);
      checks++;
      if (obs_writes != ((n > NN) ? NN : n)) begin
        errors++; $display("FAIL rand_writes pass=%0d got=%0d exp=%0d", p, obs_writes, (n > NN) ? NN : n);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; n_active = '0;
    for (int i = 0; i < NN; i++) begin w_tab[i] = '0; b_tab[i] = '0; end
    test_reset();
    test_single();
    test_full();
    test_backpressure();
    test_edge_counts();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
